// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises PLL lock and board reset, filters them, then releases domain resets in staggered order
// Ports: clk/rst (async active-high) | pll_locked_i, ext_rst_n_i async inputs | sw_rst_req_i sync pulse
//        domain_rst_n_o per-domain active-low resets (bit 0 first) | all_released_o | state_o | lock_loss_cnt_o
module reset_sequencer #(
   parameter int NUM_DOMAINS        = 3,
   parameter int SYNC_STAGES        = 2,
   parameter int HOLD_MIN_CYCLES    = 4,
   parameter int LOCK_FILTER_CYCLES = 16,
   parameter int STAGGER_CYCLES     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pll_locked_i,
   input  logic                   ext_rst_n_i,
   input  logic                   sw_rst_req_i,
   output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
   output logic                   all_released_o,
   output logic [1:0]             state_o,
   output logic [7:0]             lock_loss_cnt_o
);
   localparam int HW = $clog2(HOLD_MIN_CYCLES + 1);
   localparam int FW = $clog2(LOCK_FILTER_CYCLES + 1);
   localparam int SW = $clog2(STAGGER_CYCLES + 1);
   localparam logic [NUM_DOMAINS-1:0] C_ONE = 1;
   typedef enum logic [1:0] {S_HOLD, S_FILTER, S_RELEASE, S_RUN} state_t;
   state_t                   r_state, w_next;
   logic [SYNC_STAGES-1:0]   r_lock_sync, r_ext_sync;
   logic [HW-1:0]            r_hold;
   logic [FW-1:0]            r_filt;
   logic [SW-1:0]            r_stg;
   logic [2:0]               r_idx;
   logic [NUM_DOMAINS-1:0]   r_dom, w_dom_nxt;
   logic                     r_all, w_all_nxt;
   logic [7:0]               r_llc, w_llc_nxt;
   logic w_locked, w_ok, w_abort, w_hold_done, w_filt_done, w_stg_done, w_last, w_rel_step;
   assign w_locked    = r_lock_sync[SYNC_STAGES-1];
   assign w_ok        = w_locked & r_ext_sync[SYNC_STAGES-1];
   assign w_abort     = !w_ok || sw_rst_req_i;
   assign w_hold_done = r_hold == HW'(HOLD_MIN_CYCLES - 1);
   assign w_filt_done = r_filt == FW'(LOCK_FILTER_CYCLES - 1);
   assign w_stg_done  = r_stg == SW'(STAGGER_CYCLES - 1);
   // r_idx is the highest domain already released; the next step releases the last one
   assign w_last      = r_idx == 3'(NUM_DOMAINS - 2);
   assign domain_rst_n_o  = r_dom;
   assign all_released_o  = r_all;
   assign state_o         = r_state;
   assign lock_loss_cnt_o = r_llc;
   // state register, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_HOLD;
         r_lock_sync <= '0;
         r_ext_sync  <= '0;
         r_hold      <= '0;
         r_filt      <= '0;
         r_stg       <= '0;
         r_idx       <= '0;
         r_dom       <= '0;
         r_all       <= 1'b0;
         r_llc       <= '0;
      end else begin
         r_state     <= w_next;
         r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
         r_ext_sync  <= {r_ext_sync[SYNC_STAGES-2:0], ext_rst_n_i};
         r_hold      <= (r_state != S_HOLD) ? '0 : w_hold_done ? r_hold : r_hold + 1'b1;
         r_filt      <= (r_state != S_FILTER) ? '0 : r_filt + 1'b1;
         r_stg       <= (r_state != S_RELEASE || w_stg_done) ? '0 : r_stg + 1'b1;
         r_idx       <= (r_state != S_RELEASE) ? '0 : w_stg_done ? r_idx + 1'b1 : r_idx;
         r_dom       <= w_dom_nxt;
         r_all       <= w_all_nxt;
         r_llc       <= w_llc_nxt;
      end
   end
   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_HOLD:    w_next = (w_hold_done && w_ok) ? S_FILTER : S_HOLD;
         S_FILTER:  w_next = !w_ok ? S_HOLD : !w_filt_done ? S_FILTER : (NUM_DOMAINS == 1) ? S_RUN : S_RELEASE;
         S_RELEASE: w_next = w_abort ? S_HOLD : (w_stg_done && w_last) ? S_RUN : S_RELEASE;
         default:   w_next = w_abort ? S_HOLD : S_RUN;
      endcase
   end
   // output logic: releases shift a thermometer of ones in from bit 0, so order is guaranteed
   always_comb begin
      w_rel_step = (r_state == S_FILTER && (w_next == S_RELEASE || w_next == S_RUN)) ||
                   (r_state == S_RELEASE && w_next != S_HOLD && w_stg_done);
      w_dom_nxt  = (w_next == S_HOLD) ? '0 : w_rel_step ? ((r_dom << 1) | C_ONE) : r_dom;
      w_all_nxt  = w_next == S_RUN;
      w_llc_nxt  = (w_next == S_HOLD && (r_state == S_RELEASE || r_state == S_RUN) &&
                    !w_locked && r_llc != 8'hFF) ? r_llc + 8'd1 : r_llc;
   end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of boot timing, restarts, lock-loss counting and async reset
module tb_reset_sequencer;
   logic clk = 1'b0, rst = 1'b0, pll = 1'b1, ext = 1'b1, sw = 1'b0;
   logic [2:0] dom0;
   logic [0:0] dom1;
   logic [7:0] dom8;
   logic all0, all1, all8;
   logic [1:0] st0, st1, st8;
   logic [7:0] llc0, llc1, llc8;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   reset_sequencer u0 (
      .clk(clk), .rst(rst), .pll_locked_i(pll), .ext_rst_n_i(ext), .sw_rst_req_i(sw),
      .domain_rst_n_o(dom0), .all_released_o(all0), .state_o(st0), .lock_loss_cnt_o(llc0));
   reset_sequencer #(.NUM_DOMAINS(1), .STAGGER_CYCLES(1)) u1 (
      .clk(clk), .rst(rst), .pll_locked_i(pll), .ext_rst_n_i(ext), .sw_rst_req_i(sw),
      .domain_rst_n_o(dom1), .all_released_o(all1), .state_o(st1), .lock_loss_cnt_o(llc1));
   reset_sequencer #(.NUM_DOMAINS(8), .STAGGER_CYCLES(1)) u8 (
      .clk(clk), .rst(rst), .pll_locked_i(pll), .ext_rst_n_i(ext), .sw_rst_req_i(sw),
      .domain_rst_n_o(dom8), .all_released_o(all8), .state_o(st8), .lock_loss_cnt_o(llc8));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_state(input logic [1:0] s, input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (st0 !== s && n < 200);
      chk(tag, st0, s);
   endtask
   initial begin
      int x;
      #2 rst = 1'b1;
      #20;
      chk("rst_dom", dom0, 0);
      chk("rst_all", all0, 0);
      chk("rst_state", st0, 0);
      chk("rst_llc", llc0, 0);
      @(negedge clk) rst = 1'b0;
      for (int e = 0; e <= 40; e++) begin
         tick();
         chk("boot_dom", dom0, e < 19 ? 0 : e < 27 ? 1 : e < 35 ? 3 : 7);
         chk("boot_state", st0, e < 3 ? 0 : e < 19 ? 1 : e < 35 ? 2 : 3);
         chk("boot_all", all0, e >= 35);
         chk("n1_dom", dom1, e >= 19);
         chk("n1_all", all1, e >= 19);
         chk("n1_state", st1, e < 3 ? 0 : e < 19 ? 1 : 3);
         x = e < 19 ? 0 : e >= 26 ? 255 : (1 << (e - 18)) - 1;
         chk("n8_dom", dom8, x);
         chk("n8_all", all8, e >= 26);
         chk("n8_state", st8, e < 3 ? 0 : e < 19 ? 1 : e < 26 ? 2 : 3);
      end
      #2 rst = 1'b1;
      #1;
      chk("async_run_dom", dom0, 0);
      chk("async_run_all", all0, 0);
      @(negedge clk) rst = 1'b0;
      for (int e = 0; e <= 36; e++) begin
         tick();
         chk("filt_dom", dom0, e == 36 ? 1 : 0);
         if (e == 16) chk("filt_back_hold", st0, 0);
         if (e == 19) chk("filt_still_hold", st0, 0);
         if (e == 20) chk("filt_reenter", st0, 1);
         if (e == 36) chk("filt_release", st0, 2);
         pll = !(e >= 13 && e <= 15);
      end
      chk("filt_llc", llc0, 0);
      for (int e = 37; e <= 52; e++) begin
         tick();
         if (e == 44) chk("d1_release", dom0, 3);
      end
      chk("run_dom", dom0, 7);
      chk("run_all", all0, 1);
      chk("run_state", st0, 3);
      pll = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("loss_dom", dom0, i < 3 ? 7 : 0);
      end
      chk("loss_state", st0, 0);
      chk("loss_all", all0, 0);
      chk("loss_llc", llc0, 1);
      chk("loss_llc_n1", llc1, 1);
      tick();
      tick();
      pll = 1'b1;
      for (int i = 1; i <= 35; i++) begin
         tick();
         chk("relock_dom", dom0, i < 19 ? 0 : i < 27 ? 1 : i < 35 ? 3 : 7);
      end
      chk("relock_state", st0, 3);
      sw = 1'b1;
      tick();
      sw = 1'b0;
      chk("sw_state", st0, 0);
      chk("sw_dom", dom0, 0);
      chk("sw_all", all0, 0);
      for (int j = 1; j <= 36; j++) begin
         tick();
         chk("sw_rel_dom", dom0, j < 20 ? 0 : j < 28 ? 1 : j < 36 ? 3 : 7);
      end
      chk("sw_rel_state", st0, 3);
      chk("sw_llc", llc0, 1);
      ext = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("ext_dom", dom0, i < 3 ? 7 : 0);
      end
      chk("ext_state", st0, 0);
      chk("ext_llc", llc0, 1);
      ext = 1'b1;
      wait_state(2'd3, "ext_rerun");
      pll = 1'b0;
      tick();
      tick();
      chk("both_pre_state", st0, 3);
      sw = 1'b1;
      tick();
      sw = 1'b0;
      chk("both_state", st0, 0);
      chk("both_llc", llc0, 2);
      pll = 1'b1;
      for (int n = 0; n < 300; n++) begin
         wait_state(2'd2, "sat_release");
         pll = 1'b0;
         repeat (3) tick();
         pll = 1'b1;
         if (n == 99) chk("sat_mid_llc", llc0, 102);
      end
      chk("sat_llc", llc0, 255);
      wait_state(2'd2, "mid_release");
      repeat (8) tick();
      chk("mid_dom", dom0, 3);
      #3 rst = 1'b1;
      #1;
      chk("async_dom", dom0, 0);
      chk("async_all", all0, 0);
      chk("async_state", st0, 0);
      chk("async_llc", llc0, 0);
      @(negedge clk) rst = 1'b0;
      wait_state(2'd3, "post_rst_run");
      chk("post_rst_dom", dom0, 7);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 3: number of sequenced reset outputs, legal range 1..8.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop depth of each input synchroniser, legal range at least 2.
REQ-003 SHALL have parameter HOLD_MIN_CYCLES, default 4: minimum cycles spent in HOLD, legal range at least 1.
REQ-004 SHALL have parameter LOCK_FILTER_CYCLES, default 16: cycles that inputs must stay good before release, legal range at least 1.
REQ-005 SHALL have parameter STAGGER_CYCLES, default 8: cycles between successive domain releases, legal range at least 1.
REQ-006 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  sole clock; rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have pll_locked_i  in  1: PLL lock, asynchronous to clk.
REQ-008 SHALL have ext_rst_n_i  in  1: board reset button, active-low, asynchronous.
REQ-009 SHALL have sw_rst_req_i  in  1: synchronous single-cycle software/debug reset request.
REQ-010 SHALL have domain_rst_n_o  out  NUM_DOMAINS: per-domain active-low resets; bit 0 is released first.
REQ-011 SHALL have all_released_o  out  1: high only when every domain is released.
REQ-012 SHALL have state_o  out  2: current FSM state, HOLD=0, FILTER=1, RELEASE=2, RUN=3.
REQ-013 SHALL have lock_loss_cnt_o  out  8: saturating count of lock-loss events.

Function
REQ-014 SHALL pass pll_locked_i and ext_rst_n_i through SYNC_STAGES-flop synchronisers; ok = locked_sync AND ext_rst_n_sync.
REQ-015 SHALL register all outputs; no combinational path from any input to any output.
REQ-016 HOLD: all domain_rst_n_o = 0, all_released_o = 0; hold_cnt is cleared on entry and increments saturating each cycle in HOLD.
REQ-017 HOLD -> FILTER SHALL occur when hold_cnt >= HOLD_MIN_CYCLES-1 and ok = 1; filter_cnt is cleared on entry.
REQ-018 FILTER: ok = 0 SHALL cause -> HOLD; otherwise filter_cnt increments; filter_cnt == LOCK_FILTER_CYCLES-1 with ok = 1 SHALL cause -> RELEASE.
REQ-019 RELEASE entry edge SHALL set domain_rst_n_o[0] = 1; domain k SHALL be set STAGGER_CYCLES cycles after domain k-1, using a stagger counter and an index counter.
REQ-020 On the edge releasing domain NUM_DOMAINS-1: -> RUN and all_released_o = 1 on that same edge.
REQ-021 NUM_DOMAINS = 1: FILTER -> RUN directly, and domain 0 and all_released_o rise on the same edge.
REQ-022 Released bits SHALL stay 1 until the next HOLD entry; no bit ever deasserts out of order.
REQ-023 In RELEASE or RUN, ok = 0 or sw_rst_req_i = 1 SHALL force -> HOLD on the next edge, with all domain_rst_n_o = 0 and all_released_o = 0 on that same edge.
REQ-024 sw_rst_req_i SHALL be ignored in HOLD and FILTER.
REQ-025 lock_loss_cnt_o SHALL increment by 1, saturating at 255, on each RELEASE/RUN -> HOLD transition where locked_sync = 0.
REQ-026 Transitions caused only by ext_rst_n_i or sw_rst_req_i SHALL NOT increment lock_loss_cnt_o.
REQ-027 Simultaneous lock loss and sw_rst_req_i SHALL take a single HOLD transition and a single counter increment.
REQ-028 Input glitches shorter than the synchroniser latency plus 1 cycle that clear before FILTER completes SHALL only restart the sequence and SHALL never release a domain.

Reset
REQ-029 rst asserted SHALL immediately and asynchronously force: state HOLD, domain_rst_n_o = 0, all_released_o = 0, lock_loss_cnt_o = 0, state_o = 0, all counters 0, synchroniser flops 0.
REQ-030 rst asserted mid-RELEASE or mid-RUN SHALL re-assert every domain reset without waiting for a clock edge.
REQ-031 After rst deasserts, the sequence SHALL restart from HOLD.

Verification
REQ-032 Cold boot (defaults; pll_locked_i = 1 and ext_rst_n_i = 1 before rst falls): domain 0 rises on edge 19 after rst deassert (edge 0 = first edge), domain 1 on edge 27, domain 2 and all_released_o on edge 35, with state_o sequence 0,1,2,3.
REQ-033 Filter restart: pll_locked_i drops for 3 cycles at FILTER cnt 10 -> return to HOLD, no domain released, full 16-cycle filter repeated, lock_loss_cnt_o stays 0.
REQ-034 Lock loss in RUN: pll_locked_i falls -> all domain_rst_n_o = 0 within SYNC_STAGES+1 edges, lock_loss_cnt_o = 1, sequence restarts once lock returns.
REQ-035 Software reset in RUN: one-cycle sw_rst_req_i -> next edge all outputs 0 and state_o = 0, then release after HOLD_MIN+FILTER+stagger time, lock_loss_cnt_o unchanged.
REQ-036 Saturation and async reset: 300 lock-loss cycles -> lock_loss_cnt_o = 255; asserting rst mid-RELEASE between clock edges -> domain_rst_n_o = 000 before the next edge.
REQ-037 Parameter sweep NUM_DOMAINS = 1 and 8, STAGGER_CYCLES = 1 -> release order and spacing match REQ-019 to REQ-021.
